// File: rtl/cpu_pipe_pkg.sv
// Shared constants for the pipelined CPU: control-bundle bit positions and default widths.
package cpu_pipe_pkg;

    localparam int CTRL_WREG   = 0;
    localparam int CTRL_M2REG  = 1;
    localparam int CTRL_WMEM   = 2;
    localparam int CTRL_JAL    = 3;
    localparam int CTRL_ALUIMM = 4;
    localparam int CTRL_SHIFT  = 5;

    localparam int CTRLW_DEF = 6;
    localparam int ALUCW_DEF = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_idex_reg.sv
// ID/EX pipeline register with valid bit, stall/flush, load-use bubble insertion
// and saturating stall/bubble performance counters.
module pipe_idex_reg
    import cpu_pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NOPS  = 2,
    parameter int CTRLW = CTRLW_DEF,
    parameter int ALUCW = ALUCW_DEF,
    parameter int RNW   = 5,
    parameter int CNTW  = 16
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 perf_clr,
    input  logic                 dvalid,
    input  logic [CTRLW-1:0]     dctrl,
    input  logic [XLEN-1:0]      dpc4,
    input  logic [NOPS*XLEN-1:0] dops,
    input  logic [XLEN-1:0]      dimm,
    input  logic [ALUCW-1:0]     daluc,
    input  logic [RNW-1:0]       drn,
    input  logic [NOPS*RNW-1:0]  drs,
    input  logic [NOPS-1:0]      duse,
    output logic                 evalid,
    output logic [CTRLW-1:0]     ectrl,
    output logic [XLEN-1:0]      epc4,
    output logic [NOPS*XLEN-1:0] eops,
    output logic [XLEN-1:0]      eimm,
    output logic [ALUCW-1:0]     ealuc,
    output logic [RNW-1:0]       ern,
    output logic                 lu_hazard,
    output logic [CNTW-1:0]      stall_cnt,
    output logic [CNTW-1:0]      bubble_cnt
);

    logic [NOPS-1:0] src_match;
    logic            e_is_load;
    logic            bubble;
    logic            bubble_inc;

    for (genvar g = 0; g < NOPS; g++) begin : g_src
        assign src_match[g] = duse[g] && (drs[g*RNW +: RNW] == ern);
    end

    // Only a valid load that writes a nonzero register can create a load-use dependency.
    assign e_is_load = evalid && ectrl[CTRL_M2REG] && ectrl[CTRL_WREG] && (ern != '0);
    assign lu_hazard = dvalid && e_is_load && (|src_match);

    assign bubble     = flush || lu_hazard;
    assign bubble_inc = !stall && (bubble || !dvalid);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            evalid <= 1'b0;
            ectrl  <= '0;
            epc4   <= '0;
            eops   <= '0;
            eimm   <= '0;
            ealuc  <= '0;
            ern    <= '0;
        end else if (stall) begin
            evalid <= evalid;
        end else if (bubble) begin
            // Datapath is left as-is; clearing ectrl is what keeps wreg/wmem from leaking.
            evalid <= 1'b0;
            ectrl  <= '0;
        end else begin
            evalid <= dvalid;
            ectrl  <= dvalid ? dctrl : '0;
            epc4   <= dpc4;
            eops   <= dops;
            eimm   <= dimm;
            ealuc  <= daluc;
            ern    <= drn;
        end
    end

    sat_counter #(.W(CNTW)) u_stall_cnt (
        .clock  (clock),
        .resetn (resetn),
        .clr    (perf_clr),
        .inc    (stall),
        .cnt    (stall_cnt)
    );

    sat_counter #(.W(CNTW)) u_bubble_cnt (
        .clock  (clock),
        .resetn (resetn),
        .clr    (perf_clr),
        .inc    (bubble_inc),
        .cnt    (bubble_cnt)
    );

endmodule
